// File: rtl/ifetch_queue_pkg.sv
// Shared types and defaults for the instruction prefetch queue.
// The optional same-cycle response bypass is enabled by defining IFETCH_BYPASS_EN.
package ifetch_queue_pkg;

  localparam int          IFQ_DEPTH_DEFAULT    = 4;
  localparam logic [31:0] IFQ_RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          INST_WIDTH           = 32;
  localparam logic [31:0] PC_STEP              = 32'd4;

  // FETCH: no stale responses owed. DRAIN: discarding responses from before a redirect.
  typedef enum logic [0:0] {
    ST_FETCH = 1'b0,
    ST_DRAIN = 1'b1
  } ifq_state_e;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] ir;
  } ifq_entry_t;

  // Fetch addresses are always word aligned; the low two bits are discarded.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_queue_chk.sv
// Structural invariants of the prefetch queue: the credit scheme must never
// let a response push into a full queue, and owed responses stay bounded.
module ifetch_queue_chk #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input logic          clk,
  input logic          rst_n,
  input logic          push,
  input logic          pop,
  input logic [CW-1:0] count,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] drop
);

  logic [CW:0] credit_s;

  // Combined occupancy used by the credit invariant.
  always_comb begin
    credit_s = {1'b0, count} + {1'b0, outstanding};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count == CW'(DEPTH))));

  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    credit_s <= (CW + 1)'(DEPTH));

  a_drop_owed: assert property (@(posedge clk) disable iff (!rst_n)
    drop <= outstanding);

endmodule

// File: rtl/ifetch_queue_fifo.sv
// Synchronous FIFO holding {pc, ir} entries. Flush empties it in one cycle.
// A pop on an empty FIFO is ignored; a push into a full FIFO is only accepted
// when a pop happens in the same cycle.
module ifetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH_DEFAULT,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          push,
  input  ifq_entry_t    push_data,
  input  logic          pop,
  output ifq_entry_t    head_data,
  output logic [CW-1:0] count
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  ifq_entry_t    mem_r [DEPTH];
  logic [AW-1:0] wptr_r;
  logic [AW-1:0] rptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify push/pop against the current occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);
  end

  // Pointer and occupancy bookkeeping; flush wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else if (flush) begin
      wptr_r  <= {AW{1'b0}};
      rptr_r  <= {AW{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      if (do_push_s) wptr_r <= wptr_r + 1'b1;
      if (do_pop_s)  rptr_r <= rptr_r + 1'b1;
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; contents are only observed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push_s && !flush) mem_r[wptr_r] <= push_data;
  end

  assign head_data = mem_r[rptr_r];
  assign count     = count_r;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction prefetch unit: in-order word fetches under a credit limit,
// DEPTH-entry {pc, ir} queue towards decode, redirect flush with discard of
// responses still owed from before the redirect.
// Optional: IFETCH_BYPASS_EN presents a response straight to decode when the
// queue is empty and nothing stale is owed.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int          DEPTH    = IFQ_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = IFQ_RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [31:0] ir,
  output logic [31:0] ir_pc
);

  localparam int          CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   fpc_r;
  logic [31:0]   rpc_r;
  logic [CW-1:0] outstanding_r;
  logic [CW-1:0] drop_r;
  ifq_state_e    state_r;
  ifq_state_e    state_nxt_s;

  logic [CW-1:0] fifo_count_s;
  ifq_entry_t    fifo_head_s;
  ifq_entry_t    push_entry_s;
  logic [CW:0]   credit_s;
  logic          req_valid_s;
  logic          req_fire_s;
  logic          rsp_keep_s;
  logic          bypass_s;
  logic          push_s;
  logic          pop_s;
  logic          ir_valid_s;
  logic [CW-1:0] outstanding_nxt_s;
  logic [CW-1:0] drop_nxt_s;

  // Handshake qualification: credit-limited requests, redirect suppresses everything.
  always_comb begin
    credit_s    = {1'b0, fifo_count_s} + {1'b0, outstanding_r};
    req_valid_s = rst_n && !redirect_valid && (credit_s < DEPTH_W);
    req_fire_s  = req_valid_s && imem_req_ready;
    rsp_keep_s  = imem_rsp_valid && (drop_r == {CW{1'b0}}) && !redirect_valid;
`ifdef IFETCH_BYPASS_EN
    bypass_s    = rsp_keep_s && (fifo_count_s == {CW{1'b0}});
`else
    bypass_s    = 1'b0;
`endif
    ir_valid_s  = !redirect_valid && ((fifo_count_s != {CW{1'b0}}) || bypass_s);
    pop_s       = ir_valid_s && ir_ready && (fifo_count_s != {CW{1'b0}});
    push_s      = rsp_keep_s && !(bypass_s && ir_ready);
    push_entry_s.pc = rpc_r;
    push_entry_s.ir = imem_rsp_data;
  end

  // Owed-response accounting; on redirect every response still owed becomes stale.
  always_comb begin
    if (req_fire_s && !imem_rsp_valid) begin
      outstanding_nxt_s = outstanding_r + 1'b1;
    end else if (!req_fire_s && imem_rsp_valid) begin
      outstanding_nxt_s = outstanding_r - 1'b1;
    end else begin
      outstanding_nxt_s = outstanding_r;
    end
    if (redirect_valid) begin
      drop_nxt_s = outstanding_nxt_s;
    end else if (imem_rsp_valid && (drop_r != {CW{1'b0}})) begin
      drop_nxt_s = drop_r - 1'b1;
    end else begin
      drop_nxt_s = drop_r;
    end
  end

  // Next-state logic: DRAIN while stale responses are still owed.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (redirect_valid && (drop_nxt_s != {CW{1'b0}})) state_nxt_s = ST_DRAIN;
        else state_nxt_s = ST_FETCH;
      end
      ST_DRAIN: begin
        if (drop_nxt_s == {CW{1'b0}}) state_nxt_s = ST_FETCH;
        else state_nxt_s = ST_DRAIN;
      end
      default: state_nxt_s = ST_FETCH;
    endcase
  end

  // Fetch/return PCs, counters and FSM state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fpc_r         <= RESET_PC;
      rpc_r         <= RESET_PC;
      outstanding_r <= {CW{1'b0}};
      drop_r        <= {CW{1'b0}};
      state_r       <= ST_FETCH;
    end else begin
      outstanding_r <= outstanding_nxt_s;
      drop_r        <= drop_nxt_s;
      state_r       <= state_nxt_s;
      if (redirect_valid) begin
        fpc_r <= align_pc(redirect_pc);
        rpc_r <= align_pc(redirect_pc);
      end else begin
        if (req_fire_s) fpc_r <= fpc_r + PC_STEP;
        if (rsp_keep_s) rpc_r <= rpc_r + PC_STEP;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push     (push_s),
    .push_data(push_entry_s),
    .pop      (pop_s),
    .head_data(fifo_head_s),
    .count    (fifo_count_s)
  );

  ifetch_queue_chk #(
    .DEPTH(DEPTH),
    .CW   (CW)
  ) u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_s),
    .pop        (pop_s),
    .count      (fifo_count_s),
    .outstanding(outstanding_r),
    .drop       (drop_r)
  );

  // Decode-side view: queue head, else the bypassed response, else idle values.
  always_comb begin
    if (fifo_count_s != {CW{1'b0}}) begin
      ir    = fifo_head_s.ir;
      ir_pc = fifo_head_s.pc;
    end else if (bypass_s) begin
      ir    = imem_rsp_data;
      ir_pc = rpc_r;
    end else begin
      ir    = 32'h0000_0000;
      ir_pc = RESET_PC;
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = fpc_r;
  assign ir_valid       = ir_valid_s;

endmodule
